// File: rtl/qoi_enc_stream_pkg.sv
// Shared types, opcodes and the index hash for the streaming QOI encoder.
package qoi_types;

  // One pixel, packed so that r sits in bits [7:0] and a in [31:24].
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;

  // Previous-pixel value at the start of every frame.
  localparam pixel_t PX_INIT = 32'hFF00_0000;

  // Longest chunk: one run byte followed by a five-byte RGBA chunk.
  localparam int CHUNK_MAX = 6;

  typedef logic [2:0] chunk_len_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_CLASSIFY = 3'd2,
    ST_EMIT     = 3'd3,
    ST_TAIL     = 3'd4
  } enc_state_t;

  // Index slot of a pixel: (3r + 5g + 7b + 11a) mod 64.
  function automatic logic [5:0] qoi_hash(input pixel_t p);
    logic [12:0] sum;
    sum = 13'(p.r) * 13'd3 + 13'(p.g) * 13'd5 + 13'(p.b) * 13'd7 + 13'(p.a) * 13'd11;
    return sum[5:0];
  endfunction

endpackage

// File: rtl/qoi_enc_stream_if.sv
// Control, pixel-in and byte-out streams of the QOI encoder core.
interface qoi_enc_stream_if #(
  parameter int CNT_W = 32
);
  import qoi_types::*;

  logic             start;
  logic [CNT_W-1:0] px_count;
  logic             px_valid;
  logic             px_ready;
  pixel_t           px_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  // Producer of pixels / consumer of bytes (DMA, bus adapter, bench).
  modport master (
    output start, px_count, px_valid, px_data, out_ready,
    input  px_ready, out_valid, out_data, out_last, busy, done
  );

  // The encoder core.
  modport slave (
    input  start, px_count, px_valid, px_data, out_ready,
    output px_ready, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/qoi_enc_stream_index_ram.sv
// 64-entry recently-seen pixel table: combinational read, one synchronous write.
module qoi_index_ram
  import qoi_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [5:0] waddr,
  input  pixel_t     wdata,
  input  logic [5:0] raddr,
  output pixel_t     rdata
);

  pixel_t mem_r [64];

  // Table storage; clear wins over write so a new frame starts empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem_r[i] <= 32'h0000_0000;
    end else if (clr) begin
      for (int i = 0; i < 64; i++) mem_r[i] <= 32'h0000_0000;
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/qoi_enc_stream.sv
// Streaming QOI encoder: pixels in on a valid/ready stream, chunk bytes out.
module qoi_enc_stream
  import qoi_types::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int RUN_MAX  = 62,
  parameter int EMIT_END = 1
) (
  input logic              clk,
  input logic              rst,
  qoi_enc_stream_if.slave  bus
);

  localparam logic [5:0] RUN_MAX_L = 6'(RUN_MAX);
  localparam logic       END_L     = (EMIT_END != 0);

  enc_state_t       state_r;
  pixel_t           prev_r;
  pixel_t           px_r;
  logic [5:0]       run_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] total_r;
  logic [7:0]       buf_r [CHUNK_MAX];
  chunk_len_t       len_r;
  chunk_len_t       ptr_r;
  logic             px_ready_r;
  logic             out_valid_r;
  logic [7:0]       out_data_r;
  logic             out_last_r;
  logic             busy_r;
  logic             done_r;

  pixel_t           in_px_s;
  pixel_t           idx_px_s;
  logic [5:0]       hash_s;
  logic             same_s;
  logic             last_px_s;
  logic [5:0]       run_inc_s;
  logic [5:0]       run_byte_s;
  logic [5:0]       run_s;
  logic [7:0]       dr_s, dg_s, db_s;
  logic [7:0]       dr2_s, dg2_s, db2_s;
  logic [7:0]       dg32_s, drg8_s, dbg8_s;
  logic [7:0]       pc_s  [CHUNK_MAX];
  chunk_len_t       pl_s;
  logic [7:0]       buf_s [CHUNK_MAX];
  chunk_len_t       len_s;
  chunk_len_t       nxt_ptr_s;

  qoi_index_ram u_index (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state_r == ST_IDLE) && bus.start),
    .we    (state_r == ST_CLASSIFY),
    .waddr (hash_s),
    .wdata (px_r),
    .raddr (hash_s),
    .rdata (idx_px_s)
  );

  // Incoming pixel; three-channel builds ignore alpha and treat it as opaque.
  always_comb begin
    in_px_s = bus.px_data;
    if (CHANNELS == 3) begin
      in_px_s.a = 8'hFF;
    end else begin
      in_px_s.a = bus.px_data.a;
    end
  end

  // Chunk builder: pending run byte (if any) followed by the pixel chunk.
  always_comb begin
    hash_s     = qoi_hash(px_r);
    same_s     = (px_r == prev_r);
    last_px_s  = (count_r == total_r);
    run_inc_s  = run_r + 6'd1;
    nxt_ptr_s  = ptr_r + 3'd1;
    dr_s       = px_r.r - prev_r.r;
    dg_s       = px_r.g - prev_r.g;
    db_s       = px_r.b - prev_r.b;
    dr2_s      = dr_s + 8'd2;
    dg2_s      = dg_s + 8'd2;
    db2_s      = db_s + 8'd2;
    dg32_s     = dg_s + 8'd32;
    drg8_s     = dr_s - dg_s + 8'd8;
    dbg8_s     = db_s - dg_s + 8'd8;
    for (int i = 0; i < CHUNK_MAX; i++) pc_s[i] = 8'h00;
    pl_s = 3'd0;
    // Offsets are range-checked by biasing them to unsigned and comparing.
    if (idx_px_s == px_r) begin
      pc_s[0] = QOI_OP_INDEX | {2'b00, hash_s};
      pl_s    = 3'd1;
    end else if (px_r.a != prev_r.a) begin
      pc_s[0] = QOI_OP_RGBA;
      pc_s[1] = px_r.r;
      pc_s[2] = px_r.g;
      pc_s[3] = px_r.b;
      pc_s[4] = px_r.a;
      pl_s    = 3'd5;
    end else if ((dr2_s < 8'd4) && (dg2_s < 8'd4) && (db2_s < 8'd4)) begin
      pc_s[0] = QOI_OP_DIFF | {2'b00, dr2_s[1:0], dg2_s[1:0], db2_s[1:0]};
      pl_s    = 3'd1;
    end else if ((dg32_s < 8'd64) && (drg8_s < 8'd16) && (dbg8_s < 8'd16)) begin
      pc_s[0] = QOI_OP_LUMA | {2'b00, dg32_s[5:0]};
      pc_s[1] = {drg8_s[3:0], dbg8_s[3:0]};
      pl_s    = 3'd2;
    end else begin
      pc_s[0] = QOI_OP_RGB;
      pc_s[1] = px_r.r;
      pc_s[2] = px_r.g;
      pc_s[3] = px_r.b;
      pl_s    = 3'd4;
    end

    for (int i = 0; i < CHUNK_MAX; i++) buf_s[i] = 8'h00;
    len_s = 3'd0;
    run_s = run_r;
    if (same_s) begin
      // A run is flushed when it is full or when the frame ends inside it.
      run_byte_s = run_inc_s - 6'd1;
      if ((run_inc_s == RUN_MAX_L) || last_px_s) begin
        buf_s[0] = QOI_OP_RUN | {2'b00, run_byte_s};
        len_s    = 3'd1;
        run_s    = 6'd0;
      end else begin
        run_s    = run_inc_s;
      end
    end else begin
      run_byte_s = run_r - 6'd1;
      run_s      = 6'd0;
      if (run_r != 6'd0) begin
        buf_s[0] = QOI_OP_RUN | {2'b00, run_byte_s};
        for (int i = 1; i < CHUNK_MAX; i++) buf_s[i] = pc_s[i-1];
        len_s    = pl_s + 3'd1;
      end else begin
        for (int i = 0; i < CHUNK_MAX; i++) buf_s[i] = pc_s[i];
        len_s    = pl_s;
      end
    end
  end

  // Frame sequencer with registered stream and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      prev_r      <= PX_INIT;
      px_r        <= 32'h0000_0000;
      run_r       <= 6'd0;
      count_r     <= '0;
      total_r     <= '0;
      for (int i = 0; i < CHUNK_MAX; i++) buf_r[i] <= 8'h00;
      len_r       <= 3'd0;
      ptr_r       <= 3'd0;
      px_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            prev_r  <= PX_INIT;
            run_r   <= 6'd0;
            count_r <= '0;
            total_r <= bus.px_count;
            if (bus.px_count == '0) begin
              if (END_L) begin
                state_r     <= ST_TAIL;
                busy_r      <= 1'b1;
                out_valid_r <= 1'b1;
                out_data_r  <= 8'h00;
                out_last_r  <= 1'b0;
                ptr_r       <= 3'd0;
              end else begin
                done_r <= 1'b1;
              end
            end else begin
              state_r    <= ST_FETCH;
              busy_r     <= 1'b1;
              px_ready_r <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (bus.px_valid) begin
            px_r       <= in_px_s;
            count_r    <= count_r + CNT_W'(1);
            px_ready_r <= 1'b0;
            state_r    <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          prev_r <= px_r;
          run_r  <= run_s;
          for (int i = 0; i < CHUNK_MAX; i++) buf_r[i] <= buf_s[i];
          len_r  <= len_s;
          ptr_r  <= 3'd0;
          if (len_s != 3'd0) begin
            state_r     <= ST_EMIT;
            out_valid_r <= 1'b1;
            out_data_r  <= buf_s[0];
            out_last_r  <= (len_s == 3'd1) && last_px_s && !END_L;
          end else begin
            state_r    <= ST_FETCH;
            px_ready_r <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            if (nxt_ptr_s < len_r) begin
              ptr_r      <= nxt_ptr_s;
              out_data_r <= buf_r[nxt_ptr_s];
              out_last_r <= (nxt_ptr_s == (len_r - 3'd1)) && last_px_s && !END_L;
            end else if (!last_px_s) begin
              state_r     <= ST_FETCH;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              px_ready_r  <= 1'b1;
            end else if (END_L) begin
              state_r    <= ST_TAIL;
              ptr_r      <= 3'd0;
              out_data_r <= 8'h00;
              out_last_r <= 1'b0;
            end else begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end
          end
        end
        ST_TAIL: begin
          // End marker: seven 0x00 bytes then 0x01, counted by ptr_r.
          if (bus.out_ready) begin
            if (ptr_r == 3'd7) begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
              out_data_r  <= 8'h00;
              out_last_r  <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              ptr_r      <= nxt_ptr_s;
              out_data_r <= (nxt_ptr_s == 3'd7) ? 8'h01 : 8'h00;
              out_last_r <= (nxt_ptr_s == 3'd7);
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          px_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.px_ready  = px_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_qoi_enc_stream.sv
// Directed bench for qoi_enc_stream: three configurations, hand-computed byte streams.
module tb_qoi_enc_stream;
  import qoi_types::*;

  logic        clk;
  logic        rst_s;
  logic        start_s;
  logic [31:0] px_count_s;
  logic        px_valid_s;
  logic [31:0] px_data_s;
  logic        out_ready_s;
  int          sel;

  logic        o_valid, o_px_ready, o_last, o_busy, o_done;
  logic [7:0]  o_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] px_q   [$];
  logic [7:0]  exp_q  [$];
  logic [7:0]  got_q  [$];
  logic        got_last [$];

  // bus0: 4 ch, run 62, marker.  bus1: 4 ch, run 4, no marker.  bus2: 3 ch, run 62, marker.
  qoi_enc_stream_if #(.CNT_W(32)) bus0 ();
  qoi_enc_stream_if #(.CNT_W(32)) bus1 ();
  qoi_enc_stream_if #(.CNT_W(32)) bus2 ();

  assign bus0.start = start_s && (sel == 0);
  assign bus1.start = start_s && (sel == 1);
  assign bus2.start = start_s && (sel == 2);
  assign bus0.px_valid = px_valid_s && (sel == 0);
  assign bus1.px_valid = px_valid_s && (sel == 1);
  assign bus2.px_valid = px_valid_s && (sel == 2);
  assign bus0.px_count = px_count_s;
  assign bus1.px_count = px_count_s;
  assign bus2.px_count = px_count_s;
  assign bus0.px_data = px_data_s;
  assign bus1.px_data = px_data_s;
  assign bus2.px_data = px_data_s;
  assign bus0.out_ready = out_ready_s;
  assign bus1.out_ready = out_ready_s;
  assign bus2.out_ready = out_ready_s;

  qoi_enc_stream #(.CHANNELS(4), .CNT_W(32), .RUN_MAX(62), .EMIT_END(1)) u_dut0 (
    .clk(clk), .rst(rst_s), .bus(bus0));
  qoi_enc_stream #(.CHANNELS(4), .CNT_W(32), .RUN_MAX(4), .EMIT_END(0)) u_dut1 (
    .clk(clk), .rst(rst_s), .bus(bus1));
  qoi_enc_stream #(.CHANNELS(3), .CNT_W(32), .RUN_MAX(62), .EMIT_END(1)) u_dut2 (
    .clk(clk), .rst(rst_s), .bus(bus2));

  // Observe the selected instance.
  always_comb begin
    case (sel)
      1: begin
        o_valid = bus1.out_valid; o_px_ready = bus1.px_ready; o_data = bus1.out_data;
        o_last = bus1.out_last; o_busy = bus1.busy; o_done = bus1.done;
      end
      2: begin
        o_valid = bus2.out_valid; o_px_ready = bus2.px_ready; o_data = bus2.out_data;
        o_last = bus2.out_last; o_busy = bus2.busy; o_done = bus2.done;
      end
      default: begin
        o_valid = bus0.out_valid; o_px_ready = bus0.px_ready; o_data = bus0.out_data;
        o_last = bus0.out_last; o_busy = bus0.busy; o_done = bus0.done;
      end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] px(input int r, input int g, input int b, input int a);
    return {8'(a), 8'(b), 8'(g), 8'(r)};
  endfunction

  task automatic push_marker();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
  endtask

  // Drive px_q into instance k, collect bytes; mode 1 toggles out_ready 1-0-0-1.
  task automatic run_frame(input string tag, input int k, input int mode, input int abort_at);
    int   pi;
    int   vcnt;
    int   last_cyc;
    bit   fin;
    bit   stall;
    logic [7:0] held_d;
    logic held_l;
    logic [3:0] pat;
    pat = 4'b1001;
    pi = 0; vcnt = 0; last_cyc = -10; fin = 1'b0; stall = 1'b0;
    held_d = 8'h00; held_l = 1'b0;
    got_q.delete();
    got_last.delete();
    @(negedge clk);
    sel = k;
    px_count_s = 32'(px_q.size());
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      px_valid_s = (pi < px_q.size());
      px_data_s  = px_valid_s ? px_q[pi] : (32'h5A5A_0000 | 32'(cyc));
      out_ready_s = (mode == 1) ? pat[vcnt % 4] : 1'b1;
      if (cyc == 0) check_eq({tag, "_busy"}, 32'(o_busy), 32'd1);
      if (stall) begin
        check_eq({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
        check_eq({tag, "_hold_data"}, 32'(o_data), 32'(held_d));
        check_eq({tag, "_hold_last"}, 32'(o_last), 32'(held_l));
      end
      if (abort_at >= 0 && o_valid && got_q.size() == abort_at) begin
        rst_s = 1'b0;
        #1;
        check_eq({tag, "_rst_valid"}, 32'(o_valid), 32'd0);
        check_eq({tag, "_rst_ready"}, 32'(o_px_ready), 32'd0);
        check_eq({tag, "_rst_busy"}, 32'(o_busy), 32'd0);
        check_eq({tag, "_rst_data"}, 32'(o_data), 32'd0);
        @(negedge clk);
        rst_s = 1'b1;
        fin = 1'b1;
        break;
      end
      if (o_done) begin
        check_eq({tag, "_done_lat"}, 32'(cyc), 32'(last_cyc + 1));
        check_eq({tag, "_busy_end"}, 32'(o_busy), 32'd0);
        fin = 1'b1;
        break;
      end
      if (o_valid && out_ready_s) begin
        got_q.push_back(o_data);
        got_last.push_back(o_last);
        if (o_last) last_cyc = cyc;
      end
      stall  = o_valid && !out_ready_s;
      held_d = o_data;
      held_l = o_last;
      if (o_valid) vcnt++;
      if (px_valid_s && o_px_ready) pi++;
      @(negedge clk);
    end
    if (!fin) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    px_valid_s  = 1'b0;
    out_ready_s = 1'b0;
    @(negedge clk);
  endtask

  task automatic cmp_frame(input string tag);
    int n;
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check_eq($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst_s = 1'b0; start_s = 1'b0; px_count_s = 32'd0; px_valid_s = 1'b0;
    px_data_s = 32'd0; out_ready_s = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_ready", 32'(o_px_ready), 32'd0);
    check_eq("rst_busy",  32'(o_busy), 32'd0);
    check_eq("rst_done",  32'(o_done), 32'd0);
    check_eq("rst_data",  32'(o_data), 32'd0);
    check_eq("rst_last",  32'(o_last), 32'd0);
    rst_s = 1'b1;
    @(negedge clk);

    // Empty frame: marker only.
    px_q.delete(); exp_q.delete(); push_marker();
    run_frame("t0", 0, 0, -1); cmp_frame("t0");

    // Single pixel equal to the initial previous pixel.
    px_q = '{px(0, 0, 0, 255)};
    exp_q = '{8'hC0}; push_marker();
    run_frame("t1", 0, 0, -1); cmp_frame("t1");

    // DIFF then LUMA.
    px_q = '{px(1, 0, 0, 255), px(11, 8, 12, 255)};
    exp_q = '{8'h7A, 8'hA8, 8'hAC}; push_marker();
    run_frame("t2", 0, 0, -1); cmp_frame("t2");

    // 64-pixel run, full-length chunk then the remainder.
    px_q.delete();
    for (int i = 0; i < 64; i++) px_q.push_back(px(0, 0, 0, 255));
    exp_q = '{8'hFD, 8'hC1}; push_marker();
    run_frame("t3a", 0, 0, -1); cmp_frame("t3a");

    // Same run with RUN_MAX=4 and no end marker.
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hC3);
    run_frame("t3b", 1, 0, -1); cmp_frame("t3b");

    // RGB, RGB, then INDEX hit on slot 9.
    px_q = '{px(10, 20, 30, 255), px(200, 1, 2, 255), px(10, 20, 30, 255)};
    exp_q = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hFE, 8'hC8, 8'h01, 8'h02, 8'h09}; push_marker();
    run_frame("t4", 0, 0, -1); cmp_frame("t4");

    // Alpha change under back-pressure.
    px_q = '{px(0, 0, 0, 128)};
    exp_q = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h80}; push_marker();
    run_frame("t5a", 0, 1, -1); cmp_frame("t5a");

    // Three-channel build ignores alpha, so it is a run of one.
    exp_q = '{8'hC0}; push_marker();
    run_frame("t5b", 2, 0, -1); cmp_frame("t5b");

    // LUMA, run of two, DIFF; first aborted by reset during the run byte.
    px_q = '{px(5, 5, 5, 255), px(5, 5, 5, 255), px(5, 5, 5, 255), px(6, 5, 5, 255)};
    exp_q = '{8'hA5, 8'h88, 8'hC1, 8'h7A}; push_marker();
    run_frame("t6r", 0, 0, 2);
    check_eq("t6r_pre", 32'(got_q.size()), 32'd2);
    run_frame("t6", 0, 0, -1); cmp_frame("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
